// File: rtl/sig_gen_sim_if.sv
// AXI-Stream style word channel between the tProc queue and the player.
// Signals: tdata (waveform word), tvalid (word available), tready (player accepts).
interface sig_gen_sim_if #(
  parameter int N_DW = 160
);
  logic [N_DW-1:0] tdata;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/sig_gen_sim.sv
// Timed waveform-word player: holds each accepted word for nsamp samples,
// repeating periodic words until a new word arrives, else returning to zero.
// Ports: clk, rst (async active-high), s_axis (slave word channel),
//        dout/dout_valid (playing word), periodic (its flag), last (final sample).
module sig_gen_sim #(
  parameter int N_DW  = 160,
  parameter int N_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  sig_gen_sim_if.slave    s_axis,
  output logic [N_DW-1:0] dout,
  output logic            dout_valid,
  output logic            periodic,
  output logic            last
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  localparam logic [N_LEN-1:0] ONE = N_LEN'(1);

  state_t            r_state, w_state_nxt;
  logic [N_DW-1:0]   r_data,  w_data_nxt;
  logic [N_LEN-1:0]  r_cnt,   w_cnt_nxt;
  logic [N_LEN-1:0]  r_len,   w_len_nxt;
  logic              r_per,   w_per_nxt;
  logic [N_LEN-1:0]  w_nsamp;
  logic              w_cnt_one;
  logic              w_ready;
  logic              w_accept;

  // A zero sample count still plays for one sample.
  assign w_nsamp   = (s_axis.tdata[N_LEN-1:0] == '0) ?
                     ONE : s_axis.tdata[N_LEN-1:0];
  assign w_cnt_one = (r_cnt == ONE);
  // Ready is forced low while reset is held.
  assign w_ready   = !rst &&
                     ((r_state == IDLE) || w_cnt_one);
  assign w_accept  = s_axis.tvalid && w_ready;
  assign s_axis.tready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_per   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_per   <= w_per_nxt;
    end
  end

  // Accept is only possible in IDLE or on the final sample of a play,
  // so a load takes priority over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_per_nxt   = r_per;
    if (w_accept) begin
      w_state_nxt = PLAY;
      w_data_nxt  = s_axis.tdata;
      w_cnt_nxt   = w_nsamp;
      w_len_nxt   = w_nsamp;
      w_per_nxt   = s_axis.tdata[N_LEN];
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        PLAY: begin
          if (!w_cnt_one) begin
            w_cnt_nxt = r_cnt - ONE;
          end else if (r_per) begin
            w_cnt_nxt = r_len;
          end else begin
            w_state_nxt = IDLE;
            w_data_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    periodic   = 1'b0;
    last       = 1'b0;
    if (r_state == PLAY) begin
      dout       = r_data;
      dout_valid = 1'b1;
      periodic   = r_per;
      last       = w_cnt_one;
    end
  end

endmodule

// File: tb/tb_sig_gen_sim.sv
// Testbench for sig_gen_sim: queue-driven word source plus a
// position-based play model that predicts every output each cycle.
module tb_sig_gen_sim;
  localparam int N_DW  = 160;
  localparam int N_LEN = 16;
  localparam int VW    = N_DW + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sig_gen_sim_if #(.N_DW(N_DW)) s_axis ();
  logic [N_DW-1:0] dout;
  logic            dout_valid;
  logic            periodic;
  logic            last;

  sig_gen_sim #(.N_DW(N_DW), .N_LEN(N_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_axis),
    .dout       (dout),
    .dout_valid (dout_valid),
    .periodic   (periodic),
    .last       (last)
  );

  int total = 0;
  int bad   = 0;

  // Source: words waiting to be offered, head is on the bus.
  logic [N_DW-1:0] sendq[$];
  logic            acc_flag = 1'b0;

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (acc_flag && sendq.size() > 0) void'(sendq.pop_front());
      if (rst) sendq.delete();
      s_axis.tvalid = (sendq.size() > 0);
      s_axis.tdata  = (sendq.size() > 0) ? sendq[0] : '0;
      acc_flag      = s_axis.tvalid && s_axis.tready;
    end
  end

  // Reference: a word plays samples 0..len-1; position counts up.
  logic            m_play = 1'b0;
  logic [N_DW-1:0] m_word = '0;
  int              m_len  = 1;
  int              m_pos  = 0;
  logic            m_per  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play <= 1'b0;
      m_word <= '0;
      m_len  <= 1;
      m_pos  <= 0;
      m_per  <= 1'b0;
    end else if (m_play && m_pos < m_len - 1) begin
      m_pos <= m_pos + 1;
    end else if (s_axis.tvalid) begin
      m_play <= 1'b1;
      m_word <= s_axis.tdata;
      m_len  <= (s_axis.tdata[15:0] == 0) ? 1 : int'(s_axis.tdata[15:0]);
      m_pos  <= 0;
      m_per  <= s_axis.tdata[16];
    end else if (m_play && m_per) begin
      m_pos <= 0;
    end else begin
      m_play <= 1'b0;
    end
  end

  function automatic logic [VW-1:0] model_out();
    logic fin;
    logic rdy;
    fin = m_play && (m_pos == m_len - 1);
    rdy = !rst && (!m_play || fin);
    return {m_play ? m_word : {N_DW{1'b0}},
            m_play, m_play && m_per, fin, rdy};
  endfunction

  wire [VW-1:0] dut_vec = {dout, dout_valid, periodic, last, s_axis.tready};

  function automatic logic [N_DW-1:0] mk(input logic [15:0] ns, input logic per);
    logic [N_DW-1:0] w;
    for (int i = 0; i < 5; i++) w[i*32 +: 32] = $urandom();
    w[15:0] = ns;
    w[16]   = per;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (dut_vec !== {VW{1'b0}}) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", dut_vec);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_axis.tready !== 1'b1 || dut_vec !== model_out()) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", dut_vec, model_out());
    end
  endtask

  task automatic test_nonperiodic();
    int vc = 0;
    sendq.push_back(mk(16'd3, 1'b0));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL nonper c%0d: got %h want %h", i, dut_vec, model_out());
      end
      if (dout_valid) vc++;
      if (dout_valid && last && (vc !== 3 || s_axis.tready !== 1'b1)) begin
        bad++;
        $display("FAIL nonper_last: valid cycle %0d want 3", vc);
      end
    end
    total++;
    if (vc !== 3) begin
      bad++;
      $display("FAIL nonper_len: got %0d want 3", vc);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_DW-1:0] a, b;
    logic [N_DW-1:0] seq[8];
    int k = -1;
    a = mk(16'd2, 1'b0);
    b = mk(16'd1, 1'b0);
    sendq.push_back(a);
    sendq.push_back(b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL b2b c%0d: got %h want %h", i, dut_vec, model_out());
      end
      seq[i] = dout;
      if (k < 0 && dout_valid) k = i;
    end
    total++;
    if (k < 0 || k > 4) begin
      bad++;
      $display("FAIL b2b_start: got %0d want 0..4", k);
    end else if (seq[k] !== a || seq[k+1] !== a || seq[k+2] !== b
                 || seq[k+3] !== '0) begin
      bad++;
      $display("FAIL b2b_seq: got %h,%h want A=%h B=%h", seq[k+1], seq[k+2], a, b);
    end
  endtask

  task automatic test_periodic();
    logic [N_DW-1:0] p;
    int pc = 0;
    p = mk(16'd2, 1'b1);
    sendq.push_back(p);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL per c%0d: got %h want %h", i, dut_vec, model_out());
      end
      if (dout_valid && periodic && dout === p) pc++;
    end
    total++;
    if (pc < 7) begin
      bad++;
      $display("FAIL per_hold: got %0d cycles want >=7", pc);
    end
  endtask

  task automatic test_periodic_hold();
    logic [N_DW-1:0] q;
    int n = 0;
    int qc = 0;
    q = mk(16'd1, 1'b0);
    @(negedge clk);
    while (!(m_play && m_pos == 0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 10) begin
      bad++;
      $display("FAIL hold_wait: timeout got %0d want <10", n);
    end
    sendq.push_back(q);
    #2;
    total++;
    if (s_axis.tvalid !== 1'b1 || s_axis.tready !== 1'b0) begin
      bad++;
      $display("FAIL hold_ready: got %b want 0", s_axis.tready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL hold c%0d: got %h want %h", i, dut_vec, model_out());
      end
      if (dout_valid && dout === q) qc++;
    end
    total++;
    if (qc !== 1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_q: got %0d want 1", qc);
    end
  endtask

  task automatic test_nsamp0();
    int vc = 0;
    sendq.push_back(mk(16'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL ns0 c%0d: got %h want %h", i, dut_vec, model_out());
      end
      if (dout_valid) vc++;
    end
    total++;
    if (vc !== 1) begin
      bad++;
      $display("FAIL ns0_len: got %0d want 1", vc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int vc = 0;
    sendq.push_back(mk(16'd5, 1'b0));
    @(negedge clk);
    while (!(m_play && m_pos == 0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (dut_vec !== {VW{1'b0}} || n >= 10) begin
      bad++;
      $display("FAIL rstmid_outs: got %h want 0", dut_vec);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_axis.tready !== 1'b1 || dut_vec !== model_out()) begin
      bad++;
      $display("FAIL rstmid_rel: got %h want %h", dut_vec, model_out());
    end
    sendq.push_back(mk(16'd4, 1'b0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL rstmid c%0d: got %h want %h", i, dut_vec, model_out());
      end
      if (dout_valid) vc++;
    end
    total++;
    if (vc !== 4) begin
      bad++;
      $display("FAIL rstmid_len: got %0d want 4", vc);
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int w = 0; w < 30; w++) begin
      sendq.push_back(mk(16'($urandom_range(0, 4)),
                         (w < 29) && ($urandom_range(0, 3) == 0)));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        total++;
        if (dut_vec !== model_out()) begin
          bad++;
          $display("FAIL rand w%0d: got %h want %h", w, dut_vec, model_out());
        end
      end
    end
    while ((sendq.size() > 0 || m_play) && n < 500) begin
      @(negedge clk);
      n++;
      total++;
      if (dut_vec !== model_out()) begin
        bad++;
        $display("FAIL rand_drain c%0d: got %h want %h", n, dut_vec, model_out());
      end
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL rand_timeout: got %0d cycles want <500", n);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_nonperiodic();
    test_back_to_back();
    test_periodic();
    test_periodic_hold();
    test_nsamp0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
